// File: rtl/st7920_bus_receiver.sv
// ST7920-style parallel bus slave: synchronizes the asynchronous LCD bus, decodes
// basic/extended instructions and turns GDRAM data writes into framebuffer strobes.
module st7920_bus_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] dat,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       extended,
  output logic       graphic_on,
  output logic       display_on,
  output logic       clear_pulse,
  output logic       err_pulse
);

  typedef enum logic {IDLE, WAIT_H} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] rs_sync, rw_sync, en_sync;
  logic [7:0]             dat_sync [SYNC_STAGES];
  logic                   en_prev;
  logic                   rs_s, rw_s, en_s, fall;
  logic [7:0]             dat_s;

  logic [5:0] vert_q, vert_d;
  logic [2:0] horiz_q, horiz_d;
  logic       phase_q, phase_d;
  logic       av_q, av_d;
  logic       ext_d, g_d, don_d;
  logic [7:0] code_d, wdata_d;
  logic [9:0] addr_d;
  logic       we_d, cmdv_d, clr_d, err_d;
  logic       decode_normal;

  assign rs_s  = rs_sync[SYNC_STAGES-1];
  assign rw_s  = rw_sync[SYNC_STAGES-1];
  assign en_s  = en_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = en_prev & ~en_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_sync <= '0;
      rw_sync <= '0;
      en_sync <= '0;
      en_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) dat_sync[i] <= '0;
    end else begin
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], rs};
      rw_sync <= {rw_sync[SYNC_STAGES-2:0], rw};
      en_sync <= {en_sync[SYNC_STAGES-2:0], en};
      en_prev <= en_s;
      dat_sync[0] <= dat;
      for (int i = 1; i < SYNC_STAGES; i++) dat_sync[i] <= dat_sync[i-1];
    end
  end

  always_comb begin
    state_d       = state_q;
    vert_d        = vert_q;
    horiz_d       = horiz_q;
    phase_d       = phase_q;
    av_d          = av_q;
    ext_d         = extended;
    g_d           = graphic_on;
    don_d         = display_on;
    code_d        = cmd_code;
    addr_d        = fb_addr;
    wdata_d       = fb_wdata;
    we_d          = 1'b0;
    cmdv_d        = 1'b0;
    clr_d         = 1'b0;
    err_d         = 1'b0;
    decode_normal = 1'b0;
    if (fall && !rw_s) begin
      if (!rs_s) begin
        cmdv_d        = 1'b1;
        code_d        = dat_s;
        decode_normal = 1'b1;
        // A pending vertical address either completes or is abandoned here.
        if (state_q == WAIT_H) begin
          state_d = IDLE;
          if (dat_s[7]) begin
            horiz_d       = dat_s[2:0];
            phase_d       = 1'b0;
            av_d          = 1'b1;
            decode_normal = 1'b0;
          end else begin
            av_d = 1'b0;
          end
        end
        if (decode_normal) begin
          if (dat_s[7:5] == 3'b001) begin
            ext_d = dat_s[2];
            if (dat_s[2]) begin
              g_d = dat_s[1];
            end else begin
              av_d    = 1'b0;
              state_d = IDLE;
            end
          end else if (!extended) begin
            if (dat_s == 8'h01) clr_d = 1'b1;
            else if (dat_s[7:3] == 5'b00001) don_d = dat_s[2];
          end else if (dat_s[7]) begin
            vert_d  = dat_s[5:0];
            state_d = WAIT_H;
          end
        end
      end else begin
        if (state_q == WAIT_H) begin
          state_d = IDLE;
          av_d    = 1'b0;
          err_d   = 1'b1;
        end else if (av_q) begin
          we_d    = 1'b1;
          wdata_d = dat_s;
          addr_d  = {vert_q, horiz_q, phase_q};
          phase_d = ~phase_q;
          if (phase_q) horiz_d = horiz_q + 3'd1;
        end else if (extended) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vert_q      <= '0;
      horiz_q     <= '0;
      phase_q     <= 1'b0;
      av_q        <= 1'b0;
      extended    <= 1'b0;
      graphic_on  <= 1'b0;
      display_on  <= 1'b0;
      cmd_code    <= '0;
      fb_addr     <= '0;
      fb_wdata    <= '0;
      fb_we       <= 1'b0;
      cmd_valid   <= 1'b0;
      clear_pulse <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vert_q      <= vert_d;
      horiz_q     <= horiz_d;
      phase_q     <= phase_d;
      av_q        <= av_d;
      extended    <= ext_d;
      graphic_on  <= g_d;
      display_on  <= don_d;
      cmd_code    <= code_d;
      fb_addr     <= addr_d;
      fb_wdata    <= wdata_d;
      fb_we       <= we_d;
      cmd_valid   <= cmdv_d;
      clear_pulse <= clr_d;
      err_pulse   <= err_d;
    end
  end

endmodule

// File: tb/tb_st7920_bus_receiver.sv
// Bench for st7920_bus_receiver: directed bus transfers, a mid-sequence reset and a
// randomized transfer mix, all checked against a transfer-level model.
module tb_st7920_bus_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs, rw, en;
  logic [7:0] dat;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       extended, graphic_on, display_on, clear_pulse, err_pulse;

  st7920_bus_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rw(rw), .en(en), .dat(dat),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .extended(extended), .graphic_on(graphic_on), .display_on(display_on),
    .clear_pulse(clear_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed activity, gathered away from the active edge.
  logic [17:0] obs_q[$];
  logic [17:0] log_q[$];
  int o_cmdv = 0, o_clr = 0, o_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we) begin
        obs_q.push_back({fb_addr, fb_wdata});
        log_q.push_back({fb_addr, fb_wdata});
      end
      if (cmd_valid)   o_cmdv++;
      if (clear_pulse) o_clr++;
      if (err_pulse)   o_err++;
    end
  end

  // Reference model state, kept at the transfer level.
  logic [17:0] exp_q[$];
  int   e_cmdv = 0, e_clr = 0, e_err = 0;
  bit   m_ext, m_g, m_don, m_av, m_wait, m_ph;
  int   m_v, m_h;
  logic [7:0] e_code;
  logic [9:0] e_addr;
  logic [7:0] e_wdata;

  task automatic model_reset();
    m_ext = 0; m_g = 0; m_don = 0; m_av = 0; m_wait = 0; m_ph = 0;
    m_v = 0; m_h = 0; e_code = 8'h00; e_addr = 10'd0; e_wdata = 8'h00;
  endtask

  task automatic model_xfer(input bit mrs, input bit mrw, input logic [7:0] d);
    int a;
    bit norm;
    if (mrw) return;
    if (!mrs) begin
      e_cmdv++;
      e_code = d;
      norm = 1;
      if (m_wait) begin
        m_wait = 0;
        if (d[7]) begin
          m_h = d & 7; m_ph = 0; m_av = 1; norm = 0;
        end else begin
          m_av = 0;
        end
      end
      if (norm) begin
        if ((d >> 5) == 1) begin
          m_ext = d[2];
          if (d[2]) m_g = d[1];
          else begin m_av = 0; m_wait = 0; end
        end else if (!m_ext) begin
          if (d == 8'h01) e_clr++;
          else if ((d >> 3) == 1) m_don = d[2];
        end else if (d[7]) begin
          m_v = d & 63;
          m_wait = 1;
        end
      end
    end else begin
      if (m_wait) begin
        m_wait = 0; m_av = 0; e_err++;
      end else if (m_av) begin
        a = m_v * 16 + m_h * 2 + int'(m_ph);
        e_addr = a[9:0];
        e_wdata = d;
        exp_q.push_back({e_addr, e_wdata});
        if (m_ph) m_h = (m_h + 1) % 8;
        m_ph = !m_ph;
      end else if (m_ext) begin
        e_err++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag);
    logic [17:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 18'h3ffff;
      chk({tag, ".fb_write"}, 32'(o), 32'(e));
    end
    chk({tag, ".extra_writes"}, obs_q.size(), 0);
    obs_q.delete();
    chk({tag, ".cmd_valid_cnt"}, o_cmdv, e_cmdv);
    chk({tag, ".clear_cnt"}, o_clr, e_clr);
    chk({tag, ".err_cnt"}, o_err, e_err);
    chk({tag, ".cmd_code"}, 32'(cmd_code), 32'(e_code));
    chk({tag, ".flags"}, {extended, graphic_on, display_on}, {m_ext, m_g, m_don});
    chk({tag, ".fb_addr_hold"}, 32'(fb_addr), 32'(e_addr));
    chk({tag, ".fb_wdata_hold"}, 32'(fb_wdata), 32'(e_wdata));
    chk({tag, ".idle_pulses"}, {fb_we, cmd_valid, clear_pulse, err_pulse}, 0);
  endtask

  task automatic bus_write(input string tag, input bit wrs, input bit wrw, input logic [7:0] d);
    rs = wrs; rw = wrw; dat = d;
    repeat (2) @(posedge clk);
    #2 en = 1'b1;
    repeat (5) @(posedge clk);
    #2 en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    model_xfer(wrs, wrw, d);
    check_step(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".fb_addr"}, 32'(fb_addr), 0);
    chk({tag, ".fb_wdata"}, 32'(fb_wdata), 0);
    chk({tag, ".cmd_code"}, 32'(cmd_code), 0);
    chk({tag, ".bits"}, {fb_we, cmd_valid, extended, graphic_on, display_on, clear_pulse, err_pulse}, 0);
  endtask

  initial begin
    logic [7:0] d;
    int op;
    rst = 1'b1; rs = 1'b0; rw = 1'b0; en = 1'b0; dat = 8'h00;
    model_reset();
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Init sequence: function set, display on, clear, extended+graphic.
    bus_write("init_30", 0, 0, 8'h30);
    bus_write("init_0c", 0, 0, 8'h0C);
    bus_write("init_01", 0, 0, 8'h01);
    bus_write("init_36", 0, 0, 8'h36);
    chk("init.display_on", display_on, 1);
    chk("init.ext_g", {extended, graphic_on}, 2'b11);
    chk("init.cmd_pulses", o_cmdv, 4);
    chk("init.clear_pulses", o_clr, 1);

    // GDRAM address 0,0 then four data bytes.
    bus_write("addr_v0", 0, 0, 8'h80);
    bus_write("addr_h0", 0, 0, 8'h80);
    bus_write("wr0", 1, 0, 8'h53);
    bus_write("wr1", 1, 0, 8'h1C);
    bus_write("wr2", 1, 0, 8'h3C);
    bus_write("wr3", 1, 0, 8'h1F);
    chk("gd.size", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("gd.w0", 32'(log_q[0]), 32'({10'd0, 8'h53}));
      chk("gd.w1", 32'(log_q[1]), 32'({10'd1, 8'h1C}));
      chk("gd.w2", 32'(log_q[2]), 32'({10'd2, 8'h3C}));
      chk("gd.w3", 32'(log_q[3]), 32'({10'd3, 8'h1F}));
    end
    chk("gd.no_err", o_err, 0);

    // Horizontal wrap: vert 5, horiz 7.
    bus_write("wrap_v", 0, 0, 8'h85);
    bus_write("wrap_h", 0, 0, 8'h87);
    for (int i = 0; i < 4; i++) bus_write("wrap_wr", 1, 0, 8'hAA);
    chk("wrap.size", log_q.size(), 8);
    if (log_q.size() >= 8) begin
      chk("wrap.a0", 32'(log_q[4][17:8]), 94);
      chk("wrap.a1", 32'(log_q[5][17:8]), 95);
      chk("wrap.a2", 32'(log_q[6][17:8]), 80);
      chk("wrap.a3", 32'(log_q[7][17:8]), 81);
    end

    // Abort in WAIT_H by a non-address instruction.
    bus_write("abort_v", 0, 0, 8'h80);
    bus_write("abort_01", 0, 0, 8'h01);
    bus_write("abort_data", 1, 0, 8'h55);
    chk("abort.err", o_err, 1);
    chk("abort.no_write", log_q.size(), 8);

    // Reads are ignored; data in basic mode is silently dropped.
    bus_write("read_data", 1, 1, 8'h99);
    bus_write("basic_30", 0, 0, 8'h30);
    bus_write("basic_data", 1, 0, 8'h77);
    chk("quiet.no_write", log_q.size(), 8);
    chk("quiet.err", o_err, 1);

    // Reset in the middle of an address sequence.
    bus_write("pre_rst_36", 0, 0, 8'h36);
    bus_write("pre_rst_83", 0, 0, 8'h83);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("mid_reset");
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    bus_write("post_rst_80", 0, 0, 8'h80);
    chk("post_rst.basic", extended, 0);
    bus_write("post_rst_data", 1, 0, 8'h42);
    chk("post_rst.no_write", log_q.size(), 8);

    // Randomized transfer mix.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 11);
      case (op)
        0:       bus_write("rnd_fset", 0, 0, {3'b001, 5'($urandom_range(0, 31))});
        1:       bus_write("rnd_clear", 0, 0, 8'h01);
        2:       bus_write("rnd_disp", 0, 0, {5'b00001, 3'($urandom_range(0, 7))});
        3, 4:    bus_write("rnd_addr", 0, 0, {2'b10, 6'($urandom_range(0, 63))});
        5:       bus_write("rnd_ext", 0, 0, 8'h36);
        6:       bus_write("rnd_instr", 0, 0, 8'($urandom_range(0, 255)));
        7, 8, 9: bus_write("rnd_data", 1, 0, 8'($urandom_range(0, 255)));
        default: begin
          d = 8'($urandom_range(0, 255));
          bus_write("rnd_read", 1'($urandom_range(0, 1)), 1, d);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
